// File: rtl/robot_nav_fsm_param.sv
// robot_nav_fsm_param: grid-walking wall-follower with maintenance dwell, boundary saturation and step count
module robot_nav_fsm_param #(
  parameter int COORD_W   = 4,
  parameter int MTN_W     = 4,
  parameter int MAINT_CYC = 4,
  parameter int STEP_W    = 8,
  parameter bit LEFT_HAND = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           onoff,
  input  logic [2*COORD_W-1:0] lcn_0,
  input  logic                 sense_vld,
  input  logic [MTN_W-1:0]     mtn_sensor,
  input  logic [3:0]           cmps,
  input  logic [2:0]           wll,
  output logic [1:0]           turn,
  output logic                 driving,
  output logic [2*COORD_W-1:0] location,
  output logic [2:0]           action,
  output logic [STEP_W-1:0]    step_cnt
);
  localparam int MC_W = MAINT_CYC > 1 ? $clog2(MAINT_CYC) : 1;
  typedef enum logic [2:0] {IDLE, WAIT, DECIDE, MAINT, MOVE} state_t;
  state_t state;
  logic [2:0] wll_q;
  logic [3:0] cmps_q;
  logic [MTN_W-1:0] mtn_q;
  logic [MC_W-1:0] mcnt;
  logic [2:0] mtn_act;
  logic [1:0] tc, h0, rot, hd;
  logic r_open, f_open, l_open, blocked;
  logic [COORD_W-1:0] x, y, nx, ny;
  always_comb begin
    mtn_act = '0;
    for (int i = MTN_W-1; i >= 0; i--) if (mtn_q[i]) mtn_act = 3'(i+1);
  end
  assign r_open = ~wll_q[0];
  assign f_open = ~wll_q[1];
  assign l_open = ~wll_q[2];
  assign tc = LEFT_HAND ? (l_open ? 2'b01 : f_open ? 2'b00 : r_open ? 2'b10 : 2'b11)
                        : (r_open ? 2'b10 : f_open ? 2'b00 : l_open ? 2'b01 : 2'b11);
  // headings indexed clockwise N=0,E=1,S=2,W=3 so a turn is a modular add
  assign h0 = cmps_q[3] ? 2'd0 : cmps_q[2] ? 2'd1 : cmps_q[1] ? 2'd2 : 2'd3;
  assign rot = tc == 2'b10 ? 2'd1 : tc == 2'b01 ? 2'd3 : tc == 2'b11 ? 2'd2 : 2'd0;
  assign hd = h0 + rot;
  assign x = location[2*COORD_W-1:COORD_W];
  assign y = location[COORD_W-1:0];
  assign blocked = (hd == 2'd0 && y == '1) || (hd == 2'd1 && x == '1) ||
                   (hd == 2'd2 && y == '0) || (hd == 2'd3 && x == '0);
  assign nx = hd == 2'd1 ? x + COORD_W'(1) : hd == 2'd3 ? x - COORD_W'(1) : x;
  assign ny = hd == 2'd0 ? y + COORD_W'(1) : hd == 2'd2 ? y - COORD_W'(1) : y;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      turn     <= '0;
      driving  <= 1'b0;
      location <= '0;
      action   <= '0;
      step_cnt <= '0;
      wll_q    <= '0;
      cmps_q   <= '0;
      mtn_q    <= '0;
      mcnt     <= '0;
    end else begin
      driving <= 1'b0;
      turn    <= '0;
      if (onoff == 2'b10) state <= IDLE;
      else case (state)
        IDLE: if (onoff == 2'b01) begin
          location <= lcn_0;
          step_cnt <= '0;
          action   <= '0;
          state    <= WAIT;
        end
        WAIT: if (sense_vld) begin
          wll_q  <= wll;
          cmps_q <= cmps;
          mtn_q  <= mtn_sensor;
          state  <= DECIDE;
        end
        DECIDE: if (!$onehot(cmps_q)) begin
          action <= 3'b111;
          state  <= WAIT;
        end else if (|mtn_q) begin
          action <= mtn_act;
          mcnt   <= MC_W'(MAINT_CYC-1);
          state  <= MAINT;
        end else state <= MOVE;
        MAINT: if (mcnt == '0) state <= MOVE;
               else mcnt <= mcnt - MC_W'(1);
        MOVE: begin
          turn  <= tc;
          state <= WAIT;
          if (blocked) action <= 3'b110;
          else begin
            driving  <= 1'b1;
            location <= {nx, ny};
            if (step_cnt != '1) step_cnt <= step_cnt + STEP_W'(1);
            if (mtn_q == '0) action <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_robot_nav_fsm_param.sv
// tb_robot_nav_fsm_param: right-hand (u0) and left-hand/2-bit-step (u1) navigators checked against a timing/event model
module tb_robot_nav_fsm_param;
  localparam int MC = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] onoff = '0;
  logic [7:0] lcn_0 = '0;
  logic sense_vld = 1'b0;
  logic [3:0] mtn = '0, cmps = '0;
  logic [2:0] wll = '0;
  logic [1:0] turn0, turn1;
  logic drv0, drv1;
  logic [7:0] loc0, loc1;
  logic [2:0] act0, act1;
  logic [7:0] st0;
  logic [1:0] st1;
  int n_chk = 0, n_pass = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  robot_nav_fsm_param u0 (
    .clk(clk), .rst_n(rst_n), .onoff(onoff), .lcn_0(lcn_0), .sense_vld(sense_vld),
    .mtn_sensor(mtn), .cmps(cmps), .wll(wll), .turn(turn0), .driving(drv0),
    .location(loc0), .action(act0), .step_cnt(st0));
  robot_nav_fsm_param #(.LEFT_HAND(1'b1), .STEP_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .onoff(onoff), .lcn_0(lcn_0), .sense_vld(sense_vld),
    .mtn_sensor(mtn), .cmps(cmps), .wll(wll), .turn(turn1), .driving(drv1),
    .location(loc1), .action(act1), .step_cnt(st1));

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
  endtask

  // model: a strobe accepted at edge n decides at n+1 and moves at n+2 (+MC with maintenance)
  int n = 0, busy = 0, dec_at = -1, due = -1;
  bit run = 1'b0;
  logic [3:0] c_cmps = '0, c_mtn = '0;
  logic [2:0] c_wll = '0;
  int m_x[2], m_y[2], m_st[2], m_act[2], m_drv[2], m_trn[2];
  int dxs[4] = '{0, 1, 0, -1};
  int dys[4] = '{1, 0, -1, 0};
  int smax[2] = '{255, 3};

  task automatic do_move(input int d);
    int t, h, nx, ny;
    bit r, f, l;
    r = !c_wll[0]; f = !c_wll[1]; l = !c_wll[2];
    if (d == 1) t = l ? 1 : f ? 0 : r ? 2 : 3;
    else t = r ? 2 : f ? 0 : l ? 1 : 3;
    h = 0;
    for (int i = 0; i < 4; i++) if (c_cmps[3-i]) h = i;
    h = (h + (t == 2 ? 1 : t == 1 ? 3 : t == 3 ? 2 : 0)) % 4;
    nx = m_x[d] + dxs[h];
    ny = m_y[d] + dys[h];
    m_trn[d] = t;
    if (nx < 0 || nx > 15 || ny < 0 || ny > 15) m_act[d] = 6;
    else begin
      m_x[d] = nx; m_y[d] = ny; m_drv[d] = 1;
      if (m_st[d] < smax[d]) m_st[d]++;
      if (c_mtn == 0) m_act[d] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run = 0; dec_at = -1; due = -1; c_cmps = '0; c_mtn = '0; c_wll = '0;
      for (int d = 0; d < 2; d++) begin
        m_x[d] = 0; m_y[d] = 0; m_st[d] = 0; m_act[d] = 0; m_drv[d] = 0; m_trn[d] = 0;
      end
    end else begin
      n++;
      for (int d = 0; d < 2; d++) begin m_drv[d] = 0; m_trn[d] = 0; end
      if (onoff == 2'b10) begin
        run = 0; dec_at = -1; due = -1;
      end else if (!run) begin
        if (onoff == 2'b01) begin
          run = 1; busy = n;
          for (int d = 0; d < 2; d++) begin
            m_x[d] = lcn_0[7:4]; m_y[d] = lcn_0[3:0]; m_st[d] = 0; m_act[d] = 0;
          end
        end
      end else begin
        if (n == dec_at) begin
          int a;
          a = 0;
          if ($countones(c_cmps) != 1) a = 7;
          else for (int i = 3; i >= 0; i--) if (c_mtn[i]) a = i + 1;
          if (a != 0) for (int d = 0; d < 2; d++) m_act[d] = a;
        end
        if (n == due) for (int d = 0; d < 2; d++) do_move(d);
        if (n > busy && sense_vld) begin
          bit err;
          c_cmps = cmps; c_wll = wll; c_mtn = mtn;
          err = $countones(cmps) != 1;
          dec_at = n + 1;
          due = err ? -1 : n + 2 + (mtn != 0 ? MC : 0);
          busy = err ? n + 1 : due;
        end
      end
    end
  end

  task automatic cmp(input int d, input int trn, input int drv, input int loc, input int act, input int st);
    chk($sformatf("u%0d_turn", d), trn, m_trn[d]);
    chk($sformatf("u%0d_driving", d), drv, m_drv[d]);
    chk($sformatf("u%0d_location", d), loc, m_x[d] * 16 + m_y[d]);
    chk($sformatf("u%0d_action", d), act, m_act[d]);
    chk($sformatf("u%0d_step_cnt", d), st, m_st[d]);
  endtask

  always @(negedge clk) if (chk_on) begin
    cmp(0, int'(turn0), int'(drv0), int'(loc0), int'(act0), int'(st0));
    cmp(1, int'(turn1), int'(drv1), int'(loc1), int'(act1), int'(st1));
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic strobe(input logic [3:0] c, input logic [2:0] w, input logic [3:0] m);
    sense_vld = 1'b1; cmps = c; wll = w; mtn = m;
    @(negedge clk);
    sense_vld = 1'b0;
  endtask

  task automatic start(input logic [7:0] l);
    lcn_0 = l; onoff = 2'b10; cyc(1);
    onoff = 2'b01; cyc(1);
    onoff = 2'b00;
  endtask

  initial begin
    cyc(3);
    chk_on = 1'b1;
    chk("rst_loc", int'(loc0), 0);
    chk("rst_step", int'(st0), 0);
    rst_n = 1'b1;
    // defaults: N, right open -> turn right, x+1
    start(8'h60);
    strobe(4'b1000, 3'b110, 4'b0000); cyc(2);
    chk("t1_turn", int'(turn0), 2); chk("t1_drv", int'(drv0), 1);
    chk("t1_loc", int'(loc0), 'h70); chk("t1_step", int'(st0), 1);
    cyc(1); chk("t1_pulse_end", int'(drv0), 0);
    // maintenance dwell
    strobe(4'b1000, 3'b011, 4'b0100); cyc(1);
    chk("t2_act", int'(act0), 3);
    for (int i = 0; i < 4; i++) begin cyc(1); chk("t2_dwell_drv", int'(drv0), 0); end
    cyc(1);
    chk("t2_drv", int'(drv0), 1); chk("t2_turn", int'(turn0), 1); chk("t2_loc", int'(loc0), 'h60);
    strobe(4'b1000, 3'b011, 4'b0101); cyc(1);
    chk("t2_act_low", int'(act0), 1);
    cyc(5); chk("t2b_loc", int'(loc0), 'h50); chk("t2b_step", int'(st0), 3);
    // boundary
    start(8'hF5);
    strobe(4'b0100, 3'b101, 4'b0000); cyc(2);
    chk("t3_loc", int'(loc0), 'hF5); chk("t3_act", int'(act0), 6); chk("t3_drv", int'(drv0), 0);
    start(8'h30);
    strobe(4'b0010, 3'b101, 4'b0000); cyc(2);
    chk("t3s_loc", int'(loc0), 'h30); chk("t3s_act", int'(act0), 6);
    strobe(4'b1000, 3'b101, 4'b0000); cyc(2);
    chk("t3n_loc", int'(loc0), 'h31); chk("t3n_act", int'(act0), 0);
    // compass error
    strobe(4'b0011, 3'b101, 4'b0000); cyc(1);
    chk("t4_act", int'(act0), 7); cyc(1); chk("t4_drv", int'(drv0), 0);
    strobe(4'b0000, 3'b101, 4'b0000); cyc(1);
    chk("t4z_act", int'(act0), 7);
    strobe(4'b1000, 3'b101, 4'b0000); cyc(2);
    chk("t4r_loc", int'(loc0), 'h32); chk("t4r_act", int'(act0), 0); chk("t4r_step", int'(st0), 2);
    // stop with strobe, then strobe in IDLE
    onoff = 2'b10; sense_vld = 1'b1; cmps = 4'b1000; wll = 3'b101; cyc(1);
    onoff = 2'b00; sense_vld = 1'b0; cyc(3);
    chk("t5a_loc", int'(loc0), 'h32);
    strobe(4'b1000, 3'b101, 4'b0000); cyc(2);
    chk("t5a_idle_loc", int'(loc0), 'h32);
    // 11 and 01 outside IDLE ignored
    lcn_0 = 8'h88; onoff = 2'b01; cyc(1);
    onoff = 2'b11; strobe(4'b1000, 3'b110, 4'b0000); cyc(2);
    chk("t5d_loc", int'(loc0), 'h98); chk("t5d_step", int'(st0), 1);
    onoff = 2'b01; strobe(4'b1000, 3'b110, 4'b0000); cyc(2);
    chk("t5e_loc", int'(loc0), 'hA8); chk("t5e_step", int'(st0), 2);
    onoff = 2'b00;
    // stop during maintenance
    strobe(4'b1000, 3'b110, 4'b0001); cyc(2);
    onoff = 2'b10; cyc(1); onoff = 2'b00; cyc(6);
    chk("t5b_loc", int'(loc0), 'hA8); chk("t5b_act", int'(act0), 1); chk("t5b_step", int'(st0), 2);
    // async reset during maintenance
    start(8'h44);
    strobe(4'b1000, 3'b110, 4'b0001); cyc(2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5c_loc0", int'(loc0), 0); chk("t5c_act0", int'(act0), 0);
    chk("t5c_loc1", int'(loc1), 0); chk("t5c_act1", int'(act1), 0);
    @(negedge clk); rst_n = 1'b1;
    // handedness and step saturation
    start(8'h55);
    strobe(4'b1000, 3'b011, 4'b0000); cyc(2);
    chk("t6_turn1", int'(turn1), 1); chk("t6_loc1", int'(loc1), 'h45);
    strobe(4'b1000, 3'b111, 4'b0000); cyc(2);
    chk("t6u_turn1", int'(turn1), 3); chk("t6u_loc1", int'(loc1), 'h44);
    strobe(4'b1000, 3'b000, 4'b0000); cyc(2);
    chk("t6o_loc0", int'(loc0), 'h54); chk("t6o_loc1", int'(loc1), 'h34);
    strobe(4'b1000, 3'b111, 4'b0000); cyc(2);
    strobe(4'b1000, 3'b111, 4'b0000); cyc(2);
    chk("t6s_st1", int'(st1), 3); chk("t6s_st0", int'(st0), 5);
    chk("t6s_loc0", int'(loc0), 'h52); chk("t6s_loc1", int'(loc1), 'h32);
    cyc(2);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/robot_nav_fsm_param.md
Name: robot_nav_fsm_param

Overview:
Parametrised successor to the pipeFSM robot controller. Grid-walking robot navigator with configurable coordinate width, maintenance-channel count, maintenance dwell time and wall-follow handedness. Each navigation step is qualified by an explicit sense strobe, not by the wall inputs going non-zero. Adds boundary saturation, compass checking, a step counter and asynchronous active-low reset. Sits between the sensor front-end and the drive/turn actuators.

Parameters:
COORD_W, 4, bits per coordinate; LOCATION = {x, y}, 2*COORD_W bits wide.
MTN_W, 4, number of maintenance sensor channels; legal range 1..5.
MAINT_CYC, 4, cycles spent in MAINT per maintenance event; must be ≥1.
STEP_W, 8, STEP_CNT width.
LEFT_HAND, 0, wall-follow rule: 0 = right-hand, 1 = left-hand.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RST_N  in  1  reset, asynchronous, active-low.
ONOFF  in  2  01 = start, 10 = stop, 00 and 11 = no-op.
LCN_0  in  2*COORD_W  start location {x, y}, sampled on start.
SENSE_VLD  in  1  one-cycle strobe qualifying WLL, CMPS and MTN_SENSOR.
MTN_SENSOR  in  MTN_W  maintenance request bits.
CMPS  in  4  one-hot heading: bit3 = N, bit2 = E, bit1 = S, bit0 = W.
WLL  in  3  walls present: bit2 = left, bit1 = front, bit0 = right.
TURN  out  2  00 = none, 01 = left, 10 = right, 11 = U-turn.
DRIVING  out  1  one-cycle move pulse.
LOCATION  out  2*COORD_W  current {x, y}.
ACTION  out  3  000 = none, 001..MTN_W = maintenance channel index + 1, 110 = blocked at boundary, 111 = compass error.
STEP_CNT  out  STEP_W  successful moves since start; saturates at all-ones.

Behaviour:
- Reset (RST_N = 0, asynchronous): state = IDLE; TURN = 00, DRIVING = 0, LOCATION = 0, ACTION = 000, STEP_CNT = 0; all capture registers cleared. Reset asserted mid-step aborts the step with no move.
- States: IDLE, WAIT, DECIDE, MAINT, MOVE.
- IDLE: outputs hold their values, DRIVING = 0. ONOFF = 01 → LOCATION <= LCN_0, STEP_CNT <= 0, ACTION <= 000, go to WAIT.
- WAIT: on SENSE_VLD, capture WLL, CMPS and MTN_SENSOR, go to DECIDE. SENSE_VLD in any other state is ignored.
- DECIDE (one cycle), in priority order:
  - CMPS not one-hot → ACTION <= 111, go to WAIT; no turn, no move.
  - MTN_SENSOR ≠ 0 → ACTION <= (index of lowest set bit) + 1, go to MAINT.
  - Otherwise → go to MOVE.
- MAINT: hold for exactly MAINT_CYC cycles with DRIVING = 0 and ACTION held, then go to MOVE.
- MOVE (one cycle):
  - Turn choice, right-hand rule: right open → 10; else front open → 00; else left open → 01; else 11.
  - LEFT_HAND = 1 mirrors the rule: left first, then front, then right, else 11.
  - New heading = captured CMPS rotated by the chosen turn.
  - Step along the new heading: N → y+1, S → y−1, E → x+1, W → x−1.
  - Step would leave 0..2^COORD_W−1 → LOCATION unchanged, DRIVING = 0, ACTION <= 110, STEP_CNT unchanged.
  - Step in range → DRIVING = 1, LOCATION updated, STEP_CNT +1 (saturating); ACTION <= 000 if no maintenance occurred in this step.
  - TURN is registered with the turn code; it is 00 in every cycle except MOVE.
  - Next state: WAIT.
- Latency: SENSE_VLD sampled at edge t; DECIDE occupies cycle t+1; MOVE outputs are visible after edge t+2. With maintenance, MOVE outputs are visible after edge t+2+MAINT_CYC.
- ONOFF = 10 in any state → IDLE at the next edge with DRIVING = 0 and TURN = 00; LOCATION, ACTION and STEP_CNT hold. Stop has priority over SENSE_VLD and over an in-progress MAINT or MOVE.
- ONOFF = 01 outside IDLE is ignored; ONOFF = 11 is always ignored.
- STEP_CNT saturates at 2^STEP_W−1 and does not wrap.

Test Plan:
1. Defaults. Start with LCN_0 = 0x60; SENSE_VLD with CMPS = 1000, WLL = 110, MTN = 0 → 2 cycles later TURN = 10, DRIVING = 1 for one cycle, LOCATION = 0x70, STEP_CNT = 1, ACTION = 000.
2. MTN_SENSOR = 0100, CMPS = 1000, WLL = 011 → ACTION = 011 for 4 cycles with DRIVING = 0. Then TURN = 01, heading W, LOCATION x−1, pulse lands at t+6. MTN = 0101 gives ACTION = 001.
3. Boundary. LOCATION = 0xF5, CMPS = 0100, WLL = 101 → TURN = 00, DRIVING = 0, LOCATION stays 0xF5, ACTION = 110, STEP_CNT unchanged. Repeat with y = 0 heading S: same blocked response.
4. Compass error. CMPS = 0011, then CMPS = 0000 → ACTION = 111, TURN = 00, no DRIVING; the next valid strobe moves normally.
5. Stop and reset.
   - ONOFF = 10 in the same cycle as SENSE_VLD → IDLE, no move.
   - ONOFF = 10 during MAINT → IDLE, no move.
   - RST_N low during MAINT → all outputs 0 immediately, no clock needed.
   - ONOFF = 11 → no effect.
6. LEFT_HAND = 1. CMPS = 1000, WLL = 011 → TURN = 01, LOCATION x−1. WLL = 111 → TURN = 11, heading S, y−1. STEP_CNT with STEP_W = 2 after 5 moves = 3.
